// File: rtl/arc4_prga.sv
// RC4 pseudo-random generation and decrypt stage.
// Reads a length-prefixed ciphertext from CT memory and generates the keystream
// from the key-scheduled S array, swapping S in place. It writes the
// length-prefixed plaintext to PT memory.
module arc4_prga (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  output logic       rdy,
  output logic [7:0] s_addr,
  input  logic [7:0] s_rddata,
  output logic [7:0] s_wrdata,
  output logic       s_wren,
  output logic [7:0] ct_addr,
  input  logic [7:0] ct_rddata,
  output logic [7:0] pt_addr,
  input  logic [7:0] pt_rddata,
  output logic [7:0] pt_wrdata,
  output logic       pt_wren
);

  localparam int unsigned DW = 8;

  // Every memory read is issued in an RD_* state and its data is taken in the
  // following WAIT_* state, which matches the registered-address memory latency.
  typedef enum logic [3:0] {
    IDLE,
    RD_LEN,
    WAIT_LEN,
    WR_LEN,
    RD_SI,
    WAIT_SI,
    RD_SJ,
    WAIT_SJ,
    WR_SI,
    WR_SJ,
    RD_PAD,
    WAIT_PAD,
    WR_PT
  } state_t;

  state_t        state;
  logic [DW-1:0] len;
  logic [DW-1:0] i;
  logic [DW-1:0] j;
  logic [DW-1:0] k;
  logic [DW-1:0] si;
  logic [DW-1:0] sj;

  // PT read port is not needed for decryption.
  logic unused_pt_rddata;
  assign unused_pt_rddata = ^pt_rddata;

  // Sequencer: the state, the loop indices and all registered memory-port outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      rdy       <= 1'b1;
      len       <= '0;
      i         <= '0;
      j         <= '0;
      k         <= '0;
      si        <= '0;
      sj        <= '0;
      s_addr    <= '0;
      s_wrdata  <= '0;
      s_wren    <= 1'b0;
      ct_addr   <= '0;
      pt_addr   <= '0;
      pt_wrdata <= '0;
      pt_wren   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (en) begin
            rdy     <= 1'b0;
            ct_addr <= '0;
            state   <= RD_LEN;
          end
        end
        RD_LEN: begin
          state <= WAIT_LEN;
        end
        WAIT_LEN: begin
          len       <= ct_rddata;
          pt_addr   <= '0;
          pt_wrdata <= ct_rddata;
          pt_wren   <= 1'b1;
          state     <= WR_LEN;
        end
        WR_LEN: begin
          pt_wren <= 1'b0;
          if (len == '0) begin
            rdy   <= 1'b1;
            state <= IDLE;
          end else begin
            k      <= DW'(1);
            i      <= DW'(1);
            j      <= '0;
            s_addr <= DW'(1);
            state  <= RD_SI;
          end
        end
        RD_SI: begin
          state <= WAIT_SI;
        end
        // Latch si and immediately launch the S[j] read with the updated j.
        WAIT_SI: begin
          si     <= s_rddata;
          j      <= DW'(j + s_rddata);
          s_addr <= DW'(j + s_rddata);
          state  <= RD_SJ;
        end
        RD_SJ: begin
          state <= WAIT_SJ;
        end
        // Writes are always issued, even when i == j (the value is then unchanged).
        WAIT_SJ: begin
          sj       <= s_rddata;
          s_addr   <= i;
          s_wrdata <= s_rddata;
          s_wren   <= 1'b1;
          state    <= WR_SI;
        end
        WR_SI: begin
          s_addr   <= j;
          s_wrdata <= si;
          s_wren   <= 1'b1;
          state    <= WR_SJ;
        end
        // Pad read follows both swap writes, so it sees the swapped S.
        WR_SJ: begin
          s_wren  <= 1'b0;
          s_addr  <= DW'(si + sj);
          ct_addr <= k;
          state   <= RD_PAD;
        end
        RD_PAD: begin
          state <= WAIT_PAD;
        end
        WAIT_PAD: begin
          pt_addr   <= k;
          pt_wrdata <= s_rddata ^ ct_rddata;
          pt_wren   <= 1'b1;
          state     <= WR_PT;
        end
        // The length is compared before k increments, so L = 255 ends without wrapping.
        WR_PT: begin
          pt_wren <= 1'b0;
          if (k == len) begin
            rdy   <= 1'b1;
            state <= IDLE;
          end else begin
            k      <= DW'(k + 1'b1);
            i      <= DW'(i + 1'b1);
            s_addr <= DW'(i + 1'b1);
            state  <= RD_SI;
          end
        end
        default: begin
          s_wren  <= 1'b0;
          pt_wren <= 1'b0;
          rdy     <= 1'b1;
          state   <= IDLE;
        end
      endcase
    end
  end

endmodule
